data_memory_sized: RTL and testbench
====================================

Name: data_memory_sized

Overview:
- Parametrised next-generation data memory for the RISC-V core, placed after execute in the load/store stage.
- Supports all RV32I load and store widths: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Memory depth and read wait-states are configurable; a stall output holds the pipeline during wait-states.
- Detects misaligned accesses and returns loaded data through the register-file write port (write_req/write_addr/write_data).

Parameters:
ADDR_WIDTH, 10, word-address bits; memory holds 2**ADDR_WIDTH 32-bit words
WAIT_CYCLES, 0, extra read wait-states before load data returns (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
jump_branch_enable  input  1  flush: current op ignored, pending load cancelled
src1_value  input  32  base address register value
src2_value  input  32  store data
imm  input  32  sign-extended address offset
rd  input  5  load destination register
operation_con  input  6  operation code from the shared instruction parameter header
stall  output  1  high while a load is in wait-states; upstream holds inputs
misalign  output  1  one-cycle pulse on a rejected misaligned access
write_req  output  1  register-file write strobe, one cycle
write_addr  output  5  register-file destination
write_data  output  32  load result, extended per width

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE; stall, misalign, write_req are 0; write_addr and write_data are 0.
  - Memory contents are not cleared.
- Effective address: ea = src1_value + imm, mod 2**32.
  - Word index = ea[ADDR_WIDTH+1:2]; higher bits are ignored, so addresses alias.
- Alignment:
  - Halfword ops require ea[0]=0; word ops require ea[1:0]=0.
  - A violation makes no memory access and gives no write_req, but misalign=1 for the next cycle.
- Non-memory operation_con codes: no action; outputs idle (write_req=0, misalign=0).
- FSM states: IDLE, WAIT, RESP.
- IDLE, accepting an op (jump_branch_enable=0, aligned):
  - Store:
    - Committed at this edge through byte enables.
    - SB uses lane ea[1:0], data src2_value[7:0].
    - SH uses lanes {ea[1],0} and {ea[1],1}, data src2_value[15:0].
    - SW writes all four lanes.
    - Stores never stall and never raise write_req.
  - Load, WAIT_CYCLES=0:
    - The word is read at this edge.
    - Next cycle: write_req=1 (if rd!=0), write_addr=rd, write_data=extended result; FSM stays IDLE.
    - Back-to-back loads give one result per cycle.
  - Load, WAIT_CYCLES>0:
    - Latch ea, op and rd; load the counter with WAIT_CYCLES; go to WAIT.
    - stall=1 from the next cycle.
- WAIT:
  - stall=1; inputs are ignored except jump_branch_enable.
  - The counter decrements each cycle; at 1, go to RESP.
- RESP:
  - stall=0.
  - Drive write_req=1 (if rd!=0) for exactly one cycle with the result.
  - Return to IDLE; IDLE may accept a new op in the same cycle.
- Extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rd=0 load: the access completes and timing is unchanged, but write_req stays 0.
- jump_branch_enable=1:
  - In IDLE: the op is ignored, with no store commit and no misalign.
  - In WAIT or RESP: the pending load is cancelled; go to IDLE; write_req=0; stall falls next cycle.
- Store followed next cycle by a load to the same word: the load returns the new data.
- Reset mid-WAIT: the load is abandoned and no write_req is issued after reset release.
- write_addr and write_data hold their last value when write_req=0.

Test Plan:
- WAIT_CYCLES=0: SW of src2_value=2,4,...,200 at ea=4,8,...,400, then LW of ea=4..400 -> write_req each cycle one cycle after each load, write_data=2,4,...,200 in order.
- SB 0x80 at ea=0x101, then LB and LBU at 0x101 -> write_data=0xFFFFFF80 then 0x00000080; the other bytes of word 0x100 are unchanged.
- SH 0x1234 at ea=0x102, then LH 0x102 -> 0x00001234. LW at 0x102 -> misalign=1 for one cycle, write_req=0.
- WAIT_CYCLES=3: LW rd=5 -> stall high for 3 cycles, then one write_req with write_addr=5. With jump_branch_enable asserted on wait cycle 2 -> no write_req, stall drops.
- ADDR_WIDTH=4: SW 0xA5A5A5A5 at ea=0x40, then LW ea=0x00 -> 0xA5A5A5A5 (alias). LW with rd=0 -> write_req stays 0.
- reset_n pulsed low during WAIT -> stall, write_req, misalign are 0 immediately; a previously stored word still reads back after release.

Source files
------------

// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: load/store stage bus between the pipeline and the data memory.
interface data_memory_sized_if;
    logic        jump_branch_enable;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  operation_con;
    logic        stall;
    logic        misalign;
    logic        write_req;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    modport master (
        output jump_branch_enable, src1_value, src2_value, imm, rd, operation_con,
        input  stall, misalign, write_req, write_addr, write_data
    );

    modport slave (
        input  jump_branch_enable, src1_value, src2_value, imm, rd, operation_con,
        output stall, misalign, write_req, write_addr, write_data
    );
endinterface

// File: rtl/data_memory_sized.sv
// data_memory_sized: RV32I byte-lane data memory with configurable read wait-states.
module data_memory_sized #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic                clk,
    input logic                reset_n,
    data_memory_sized_if.slave bus_if
);
    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q;
    logic [31:0]             mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [1:0]              off_q;
    logic [5:0]              op_q;
    logic [4:0]              rd_q;
    logic [3:0]              cnt_q;
    logic                    stall_q;
    logic                    misalign_q;
    logic                    write_req_q;
    logic [4:0]              write_addr_q;
    logic [31:0]             write_data_q;

    logic [31:0]             ea;
    logic [31:0]             unused_ea;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    is_load;
    logic                    is_store;
    logic                    aligned;
    logic                    open;
    logic                    accept;
    logic [3:0]              be;
    logic [31:0]             wdata;

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [5:0] op, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        return op == OP_LB  ? {{24{b[7]}}, b} :
               op == OP_LBU ? {24'b0, b} :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'b0, h} : w;
    endfunction

    always_comb begin
        ea        = bus_if.src1_value + bus_if.imm;
        unused_ea = ea;
        idx       = ea[ADDR_WIDTH+1:2];
        is_load   = bus_if.operation_con inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        is_store  = bus_if.operation_con inside {OP_SB, OP_SH, OP_SW};
        aligned   = !(bus_if.operation_con inside {OP_LH, OP_LHU, OP_SH} && ea[0]) &&
                    !(bus_if.operation_con inside {OP_LW, OP_SW} && ea[1:0] != 2'b00);
        // RESP behaves like IDLE for new ops, so a load completing never costs a bubble
        open      = state_q != WAIT && !bus_if.jump_branch_enable;
        accept    = open && (is_load || is_store) && aligned;
        be        = !(accept && is_store)            ? 4'b0000 :
                    bus_if.operation_con == OP_SB    ? 4'b0001 << ea[1:0] :
                    bus_if.operation_con == OP_SH    ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata     = bus_if.operation_con == OP_SB ? {4{bus_if.src2_value[7:0]}} :
                    bus_if.operation_con == OP_SH ? {2{bus_if.src2_value[15:0]}} : bus_if.src2_value;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            off_q        <= 2'b00;
            op_q         <= 6'd0;
            rd_q         <= 5'd0;
            cnt_q        <= 4'd0;
            stall_q      <= 1'b0;
            misalign_q   <= 1'b0;
            write_req_q  <= 1'b0;
            write_addr_q <= 5'd0;
            write_data_q <= 32'd0;
        end else begin
            write_req_q <= 1'b0;
            misalign_q  <= 1'b0;
            if (state_q == WAIT) begin
                if (bus_if.jump_branch_enable) begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end else if (cnt_q == 4'd1) begin
                    state_q <= RESP;
                    stall_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end else begin
                state_q <= IDLE;
                if (state_q == RESP && !bus_if.jump_branch_enable && rd_q != 5'd0) begin
                    write_req_q  <= 1'b1;
                    write_addr_q <= rd_q;
                    write_data_q <= ext(mem[idx_q], op_q, off_q);
                end
                if (open && (is_load || is_store) && !aligned) misalign_q <= 1'b1;
                if (accept && is_load) begin
                    if (WAIT_CYCLES == 0) begin
                        if (bus_if.rd != 5'd0) begin
                            write_req_q  <= 1'b1;
                            write_addr_q <= bus_if.rd;
                            write_data_q <= ext(mem[idx], bus_if.operation_con, ea[1:0]);
                        end
                    end else begin
                        state_q <= WAIT;
                        stall_q <= 1'b1;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        idx_q   <= idx;
                        off_q   <= ea[1:0];
                        op_q    <= bus_if.operation_con;
                        rd_q    <= bus_if.rd;
                    end
                end
            end
        end
    end

    assign bus_if.stall      = stall_q;
    assign bus_if.misalign   = misalign_q;
    assign bus_if.write_req  = write_req_q;
    assign bus_if.write_addr = write_addr_q;
    assign bus_if.write_data = write_data_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed checks on three configurations sharing one stimulus bus.
module tb_data_memory_sized;
    localparam logic [5:0] NOP = 6'd0,  LB  = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5,  SB  = 6'd6, SH = 6'd7, SW = 6'd8, ALU = 6'd20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic        jbe = 1'b0;
    logic [31:0] s1 = '0, s2 = '0, im = '0;
    logic [4:0]  rdv = '0;
    logic [5:0]  op = NOP;
    int          n_assert = 0;
    int          n_fail = 0;

    data_memory_sized_if if0 ();
    data_memory_sized_if if3 ();
    data_memory_sized_if if4 ();

    assign {if0.jump_branch_enable, if3.jump_branch_enable, if4.jump_branch_enable} = {3{jbe}};
    assign {if0.src1_value, if3.src1_value, if4.src1_value} = {3{s1}};
    assign {if0.src2_value, if3.src2_value, if4.src2_value} = {3{s2}};
    assign {if0.imm, if3.imm, if4.imm} = {3{im}};
    assign {if0.rd, if3.rd, if4.rd} = {3{rdv}};
    assign {if0.operation_con, if3.operation_con, if4.operation_con} = {3{op}};

    data_memory_sized #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (.clk(clk), .reset_n(reset_n), .bus_if(if0));
    data_memory_sized #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (.clk(clk), .reset_n(rst3_n),  .bus_if(if3));
    data_memory_sized #(.ADDR_WIDTH(4),  .WAIT_CYCLES(0)) u4 (.clk(clk), .reset_n(reset_n), .bus_if(if4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set(input logic [5:0] o, input logic [31:0] a, input logic [31:0] i,
                       input logic [31:0] d, input logic [4:0] r);
        op = o; s1 = a; im = i; s2 = d; rdv = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_stall", 32'(if0.stall), 32'd0);
        chk("rst_misalign", 32'(if0.misalign), 32'd0);
        chk("rst_wreq", 32'(if0.write_req), 32'd0);
        chk("rst_waddr", 32'(if0.write_addr), 32'd0);
        chk("rst_wdata", if0.write_data, 32'd0);
        chk("rst_stall3", 32'(if3.stall), 32'd0);
        reset_n = 1'b1;
        rst3_n = 1'b1;
        step();

        for (int i = 1; i <= 100; i++) begin
            set(SW, 32'(4*i - 4), 32'd4, 32'(2*i), 5'd0);
            step();
            chk("sw_noreq", 32'(if0.write_req), 32'd0);
        end
        for (int i = 1; i <= 100; i++) begin
            set(LW, 32'(4*i), 32'd0, 32'd0, 5'(1 + i % 31));
            step();
            chk("lw_req", 32'(if0.write_req), 32'd1);
            chk("lw_addr", 32'(if0.write_addr), 32'(1 + i % 31));
            chk("lw_data", if0.write_data, 32'(2*i));
        end
        set(NOP, 0, 0, 0, 0);
        step();
        chk("nop_req", 32'(if0.write_req), 32'd0);
        chk("hold_data", if0.write_data, 32'd200);

        set(SW, 32'h100, 0, 32'h11223344, 0); step();
        set(SB, 32'h100, 1, 32'h00000080, 0); step();
        set(LB, 32'h101, 0, 0, 5'd3); step();
        chk("lb", if0.write_data, 32'hFFFFFF80);
        set(LBU, 32'h101, 0, 0, 5'd3); step();
        chk("lbu", if0.write_data, 32'h00000080);
        set(LW, 32'h100, 0, 0, 5'd3); step();
        chk("sb_lanes", if0.write_data, 32'h11228044);
        set(SH, 32'h102, 0, 32'hFFFF1234, 0); step();
        set(LH, 32'h102, 0, 0, 5'd4); step();
        chk("lh_pos", if0.write_data, 32'h00001234);
        set(SH, 32'h100, 0, 32'h00008765, 0); step();
        set(LH, 32'h100, 0, 0, 5'd4); step();
        chk("lh_neg", if0.write_data, 32'hFFFF8765);
        set(LHU, 32'h100, 0, 0, 5'd4); step();
        chk("lhu", if0.write_data, 32'h00008765);
        set(LW, 32'h104, 32'hFFFFFFFC, 0, 5'd4); step();
        chk("lw_negimm", if0.write_data, 32'h12348765);

        set(LW, 32'h102, 0, 0, 5'd8); step();
        chk("mis_lw", 32'(if0.misalign), 32'd1);
        chk("mis_lw_req", 32'(if0.write_req), 32'd0);
        set(SW, 32'h101, 0, 32'hDEADBEEF, 0); step();
        chk("pulse_lw", 32'(if0.misalign), 32'd1);
        set(LH, 32'h103, 0, 0, 5'd8); step();
        chk("mis_lh", 32'(if0.misalign), 32'd1);
        set(ALU, 32'h100, 0, 0, 5'd8); step();
        chk("alu_mis", 32'(if0.misalign), 32'd0);
        chk("alu_req", 32'(if0.write_req), 32'd0);
        chk("hold_addr", 32'(if0.write_addr), 32'd4);
        jbe = 1'b1;
        set(SW, 32'h100, 0, 32'd0, 0); step();
        set(LW, 32'h101, 0, 0, 5'd9); step();
        chk("jbe_mis", 32'(if0.misalign), 32'd0);
        jbe = 1'b0;
        set(LW, 32'h100, 0, 0, 5'd9); step();
        chk("no_commit", if0.write_data, 32'h12348765);
        set(LBU, 32'h103, 0, 0, 5'd9); step();
        chk("lbu_b3", if0.write_data, 32'h00000012);

        set(NOP, 0, 0, 0, 0);
        repeat (8) step();
        set(SW, 32'h200, 0, 32'hCAFEF00D, 0); step();
        set(LW, 32'h200, 0, 0, 5'd5); step();
        set(NOP, 0, 0, 0, 0);
        chk("w3_stall1", 32'(if3.stall), 32'd1);
        step();
        chk("w3_stall2", 32'(if3.stall), 32'd1);
        step();
        chk("w3_stall3", 32'(if3.stall), 32'd1);
        chk("w3_noreq3", 32'(if3.write_req), 32'd0);
        step();
        chk("w3_resp_stall", 32'(if3.stall), 32'd0);
        chk("w3_resp_noreq", 32'(if3.write_req), 32'd0);
        step();
        chk("w3_req", 32'(if3.write_req), 32'd1);
        chk("w3_addr", 32'(if3.write_addr), 32'd5);
        chk("w3_data", if3.write_data, 32'hCAFEF00D);
        step();
        chk("w3_one", 32'(if3.write_req), 32'd0);

        set(LW, 32'h200, 0, 0, 5'd6); step();
        set(NOP, 0, 0, 0, 0);
        step();
        chk("jb_stall2", 32'(if3.stall), 32'd1);
        jbe = 1'b1;
        step();
        jbe = 1'b0;
        chk("jb_stall_drop", 32'(if3.stall), 32'd0);
        chk("jb_noreq0", 32'(if3.write_req), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("jb_noreq", 32'(if3.write_req), 32'd0);
        end

        set(SW, 32'h40, 0, 32'hA5A5A5A5, 0); step();
        set(LW, 32'h00, 0, 0, 5'd7); step();
        chk("alias_req", 32'(if4.write_req), 32'd1);
        chk("alias_data", if4.write_data, 32'hA5A5A5A5);
        set(LW, 32'h00, 0, 0, 5'd0); step();
        chk("rd0_req", 32'(if4.write_req), 32'd0);
        chk("rd0_hold", 32'(if4.write_addr), 32'd7);

        set(NOP, 0, 0, 0, 0);
        repeat (8) step();
        set(LW, 32'h200, 0, 0, 5'd9); step();
        set(NOP, 0, 0, 0, 0);
        step();
        rst3_n = 1'b0;
        #1;
        chk("arst_stall", 32'(if3.stall), 32'd0);
        chk("arst_req", 32'(if3.write_req), 32'd0);
        chk("arst_mis", 32'(if3.misalign), 32'd0);
        step();
        rst3_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("arst_noreq", 32'(if3.write_req), 32'd0);
        end
        set(LW, 32'h200, 0, 0, 5'd10); step();
        set(NOP, 0, 0, 0, 0);
        repeat (3) step();
        step();
        chk("arst_keep_req", 32'(if3.write_req), 32'd1);
        chk("arst_keep_data", if3.write_data, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
